// File: rtl/flag_pacer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | flag_pacer                                                               |
// | Paces bursty event requests into single-cycle flag pulses spaced at      |
// | least GAP cycles apart, with a saturating backlog and sticky overflow.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module flag_pacer #(
  parameter int CNT_W = 8,
  parameter int GAP   = 4
) (
  input  logic             clkA,
  input  logic             rst_clkA,
  input  logic             EventIn_clkA,
  output logic             FlagOut_clkA,
  output logic [CNT_W-1:0] Pending_clkA,
  output logic             Busy_clkA,
  output logic             Overflow_clkA,
  input  logic             OverflowClr_clkA
);

  localparam logic [CNT_W-1:0] c_CNT_MAX    = '1;
  localparam logic [7:0]       c_GAP_RELOAD = 8'(GAP - 2);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           r_state;
  logic [7:0]       r_gcnt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_flag;
  logic             r_ovf;

  logic w_emit;
  logic w_full;
  logic w_drop;

  assign w_emit = (r_state == IDLE) && ((r_cnt != '0) || EventIn_clkA);
  assign w_full = (r_cnt == c_CNT_MAX);
  // An event arriving on an emit edge is issued (or replaces the one issued), never counted.
  assign w_drop = EventIn_clkA && !w_emit && w_full;

  always_ff @(posedge clkA) begin
    if (rst_clkA) begin
      r_state <= IDLE;
      r_gcnt  <= 8'd0;
      r_cnt   <= '0;
      r_flag  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_flag <= w_emit;

      if (w_emit) begin
        r_state <= HOLD;
        r_gcnt  <= c_GAP_RELOAD;
      end else if (r_state == HOLD) begin
        if (r_gcnt == 8'd0) begin
          r_state <= IDLE;
        end else begin
          r_gcnt <= r_gcnt - 8'd1;
        end
      end

      if (EventIn_clkA && !w_emit && !w_full) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (!EventIn_clkA && w_emit) begin
        r_cnt <= r_cnt - 1'b1;
      end

      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (OverflowClr_clkA) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign FlagOut_clkA  = r_flag;
  assign Pending_clkA  = r_cnt;
  assign Overflow_clkA = r_ovf;
  assign Busy_clkA     = (r_cnt != '0) || (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_flag_pacer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_flag_pacer                                                            |
// | Three pacer configurations checked against a timing-rule model.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_flag_pacer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: CNT_W=8 GAP=4; instance 1: CNT_W=2 GAP=8; instance 2: CNT_W=2 GAP=2
  logic ev  [3];
  logic clr [3];
  logic rst [3];
  logic flag[3];
  logic busy[3];
  logic ovf [3];
  logic [7:0] pend0;
  logic [1:0] pend1;
  logic [1:0] pend2;

  flag_pacer #(.CNT_W(8), .GAP(4)) u_dut0 (
    .clkA(clk), .rst_clkA(rst[0]), .EventIn_clkA(ev[0]), .FlagOut_clkA(flag[0]),
    .Pending_clkA(pend0), .Busy_clkA(busy[0]), .Overflow_clkA(ovf[0]),
    .OverflowClr_clkA(clr[0]));
  flag_pacer #(.CNT_W(2), .GAP(8)) u_dut1 (
    .clkA(clk), .rst_clkA(rst[1]), .EventIn_clkA(ev[1]), .FlagOut_clkA(flag[1]),
    .Pending_clkA(pend1), .Busy_clkA(busy[1]), .Overflow_clkA(ovf[1]),
    .OverflowClr_clkA(clr[1]));
  flag_pacer #(.CNT_W(2), .GAP(2)) u_dut2 (
    .clkA(clk), .rst_clkA(rst[2]), .EventIn_clkA(ev[2]), .FlagOut_clkA(flag[2]),
    .Pending_clkA(pend2), .Busy_clkA(busy[2]), .Overflow_clkA(ovf[2]),
    .OverflowClr_clkA(clr[2]));

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Model: a pulse may be issued once GAP edges have passed since the previous one.
  int cap_v[3] = '{255, 3, 3};
  int gap_v[3] = '{4, 8, 2};
  int edge_n = 0;
  int m_cnt [3];
  int m_last[3];
  int m_flag[3];
  int m_ovf [3];
  bit m_idle, m_emit, m_drop;

  always @(posedge clk) begin
    edge_n++;
    for (int i = 0; i < 3; i++) begin
      if (rst[i]) begin
        m_cnt[i] = 0; m_last[i] = -1000; m_flag[i] = 0; m_ovf[i] = 0;
      end else begin
        m_idle = (edge_n - m_last[i]) >= gap_v[i];
        m_emit = m_idle && (m_cnt[i] != 0 || ev[i]);
        m_flag[i] = m_emit ? 1 : 0;
        if (m_emit) m_last[i] = edge_n;
        m_drop = 1'b0;
        if (ev[i] && !m_emit) begin
          if (m_cnt[i] < cap_v[i]) m_cnt[i]++;
          else m_drop = 1'b1;
        end else if (!ev[i] && m_emit) begin
          m_cnt[i]--;
        end
        if (m_drop) m_ovf[i] = 1;
        else if (clr[i]) m_ovf[i] = 0;
      end
    end
  end

  int pc  [3] = '{0, 0, 0};
  int peak[3] = '{0, 0, 0};
  int act_pend[3];

  always @(negedge clk) begin
    act_pend[0] = int'(pend0);
    act_pend[1] = int'(pend1);
    act_pend[2] = int'(pend2);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("flag%0d", i), int'(flag[i]), m_flag[i]);
      chk($sformatf("pend%0d", i), act_pend[i], m_cnt[i]);
      chk($sformatf("busy%0d", i), int'(busy[i]),
          (m_cnt[i] != 0 || (edge_n - m_last[i]) <= gap_v[i] - 2) ? 1 : 0);
      chk($sformatf("ovf%0d", i), int'(ovf[i]), m_ovf[i]);
      if (flag[i] === 1'b1) pc[i]++;
      if (act_pend[i] > peak[i]) peak[i] = act_pend[i];
    end
  end

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      ev[i] = 1'b0; clr[i] = 1'b0; rst[i] = 1'b1;
    end
    cyc(2);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    cyc(3);
    chk("reset_flag", int'(flag[0]), 0);
    chk("reset_pend", int'(pend0), 0);
    chk("reset_busy", int'(busy[0]), 0);
    chk("reset_ovf", int'(ovf[0]), 0);

    // Single event on an idle block
    ev[0] = 1'b1; cyc(1); ev[0] = 1'b0;
    chk("single_pulse", int'(flag[0]), 1);
    chk("single_pend", int'(pend0), 0);
    cyc(1);
    chk("single_pulse_end", int'(flag[0]), 0);
    chk("single_busy_hold", int'(busy[0]), 1);
    cyc(1);
    chk("single_busy_last", int'(busy[0]), 1);
    cyc(1);
    chk("single_busy_low", int'(busy[0]), 0);
    cyc(3);

    // Burst of 5 back-to-back events
    pc[0] = 0; peak[0] = 0;
    ev[0] = 1'b1; cyc(5); ev[0] = 1'b0;
    cyc(30);
    chk("burst_pulses", pc[0], 5);
    chk("burst_peak", peak[0], 3);
    chk("burst_ovf", int'(ovf[0]), 0);

    // Saturation with a clear landing on a drop edge
    pc[1] = 0; peak[1] = 0;
    ev[1] = 1'b1; cyc(5);
    clr[1] = 1'b1; cyc(1);
    ev[1] = 1'b0; clr[1] = 1'b0;
    chk("sat_ovf_set_wins", int'(ovf[1]), 1);
    chk("sat_pend_full", int'(pend1), 3);
    cyc(40);
    chk("sat_pulses", pc[1], 4);
    chk("sat_peak", peak[1], 3);
    chk("sat_ovf_sticky", int'(ovf[1]), 1);
    clr[1] = 1'b1; cyc(1); clr[1] = 1'b0;
    chk("sat_ovf_cleared", int'(ovf[1]), 0);

    // Full counter with event on the emit edge, GAP=2
    pc[2] = 0;
    ev[2] = 1'b1; cyc(7); ev[2] = 1'b0;
    chk("full_emit_pend", int'(pend2), 3);
    chk("full_emit_ovf", int'(ovf[2]), 0);
    cyc(20);
    chk("full_emit_pulses", pc[2], 7);
    chk("full_emit_ovf_end", int'(ovf[2]), 0);

    // Reset in the middle of a backlog
    ev[0] = 1'b1; cyc(4);
    chk("mid_pend", int'(pend0), 3);
    ev[0] = 1'b0; rst[0] = 1'b1; cyc(1); rst[0] = 1'b0;
    chk("rst_flag", int'(flag[0]), 0);
    chk("rst_pend", int'(pend0), 0);
    chk("rst_busy", int'(busy[0]), 0);
    pc[0] = 0;
    cyc(20);
    chk("rst_no_pulses", pc[0], 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
